// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - interrupt entry sequencer: flush, push PC/flags, fetch vector, redirect PC
module interrupt_sequencer #(
    parameter int                    PC_WIDTH   = 32,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FLAG_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] VEC_ADDR   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  int_req,
    input  logic                  stall,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic [FLAG_WIDTH-1:0] flags_in,
    input  logic [ADDR_WIDTH-1:0] sp_in,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  flush,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  sp_dec,
    output logic                  pc_load,
    output logic [PC_WIDTH-1:0]   pc_out,
    output logic                  flags_clear
);

    typedef enum logic [2:0] {
        IDLE, FLUSH, PUSH_HI, PUSH_LO, PUSH_FL, VEC_HI, VEC_LO, LOAD
    } state_t;

    // Low half of the vector sits one word above the high half, wrapping at the top of memory.
    localparam logic [ADDR_WIDTH-1:0] VEC_ADDR_LO = VEC_ADDR + ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic                  pending_q, pending_d;
    logic [PC_WIDTH-1:0]   pc_snap_q, pc_snap_d;
    logic [FLAG_WIDTH-1:0] fl_snap_q, fl_snap_d;
    logic [DATA_WIDTH-1:0] vec_hi_q, vec_hi_d;
    logic [DATA_WIDTH-1:0] vec_lo_q, vec_lo_d;
    logic [PC_WIDTH-1:0]   pc_out_q, pc_out_d;

    // State and capture registers; reset aborts any sequence in flight and drops a pending request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            pc_snap_q <= '0;
            fl_snap_q <= '0;
            vec_hi_q  <= '0;
            vec_lo_q  <= '0;
            pc_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            pc_snap_q <= pc_snap_d;
            fl_snap_q <= fl_snap_d;
            vec_hi_q  <= vec_hi_d;
            vec_lo_q  <= vec_lo_d;
            pc_out_q  <= pc_out_d;
        end
    end

    // Next-state logic; FLUSH and LOAD always advance, push and vector states wait out a stall.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        pc_snap_d = pc_snap_q;
        fl_snap_d = fl_snap_q;
        vec_hi_d  = vec_hi_q;
        vec_lo_d  = vec_lo_q;
        pc_out_d  = pc_out_q;

        // A request arriving mid-sequence is remembered once; repeats merge into the same bit.
        if (state_q != IDLE && int_req) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (int_req || pending_q) begin
                    pc_snap_d = pc_in;
                    fl_snap_d = flags_in;
                    pending_d = 1'b0;
                    state_d   = FLUSH;
                end
            end
            FLUSH:   state_d = PUSH_HI;
            PUSH_HI: if (!stall) state_d = PUSH_LO;
            PUSH_LO: if (!stall) state_d = PUSH_FL;
            PUSH_FL: if (!stall) state_d = VEC_HI;
            VEC_HI: begin
                if (!stall) begin
                    vec_hi_d = mem_rdata;
                    state_d  = VEC_LO;
                end
            end
            VEC_LO: begin
                if (!stall) begin
                    vec_lo_d = mem_rdata;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                pc_out_d = {vec_hi_q, vec_lo_q};
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode; only sp_dec looks at stall so the SP moves exactly once per push.
    always_comb begin
        busy        = 1'b0;
        flush       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        sp_dec      = 1'b0;
        pc_load     = 1'b0;
        flags_clear = 1'b0;
        pc_out      = pc_out_q;

        case (state_q)
            FLUSH: begin
                busy  = 1'b1;
                flush = 1'b1;
            end
            PUSH_HI, PUSH_LO, PUSH_FL: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = sp_in;
                sp_dec    = !stall;
                if (state_q == PUSH_HI) begin
                    mem_wdata = pc_snap_q[PC_WIDTH-1:DATA_WIDTH];
                end else if (state_q == PUSH_LO) begin
                    mem_wdata = pc_snap_q[DATA_WIDTH-1:0];
                end else begin
                    mem_wdata = DATA_WIDTH'(fl_snap_q);
                end
            end
            VEC_HI: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = VEC_ADDR;
            end
            VEC_LO: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = VEC_ADDR_LO;
            end
            LOAD: begin
                busy        = 1'b1;
                pc_load     = 1'b1;
                flags_clear = 1'b1;
                pc_out      = {vec_hi_q, vec_lo_q};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - scoreboard bench for interrupt_sequencer
module tb_interrupt_sequencer;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        int_req = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc_in = '0;
    logic [2:0]  flags_in = '0;
    logic [31:0] sp = 32'h0000_0FFF;
    logic [15:0] vec_hi_val = '0;
    logic [15:0] vec_lo_val = '0;

    logic        busy, flush, mem_read, mem_write, sp_dec, pc_load, flags_clear;
    logic [31:0] mem_addr, pc_out;
    logic [15:0] mem_wdata, mem_rdata;

    logic        w_busy, w_flush, w_mem_read, w_mem_write, w_sp_dec, w_pc_load, w_flags_clear;
    logic [31:0] w_mem_addr, w_pc_out;
    logic [15:0] w_mem_wdata, w_mem_rdata;

    assign mem_rdata   = (mem_addr == 32'd2) ? vec_hi_val :
                         (mem_addr == 32'd3) ? vec_lo_val : 16'hDEAD;
    assign w_mem_rdata = (w_mem_addr == 32'hFFFF_FFFF) ? vec_hi_val :
                         (w_mem_addr == 32'd0)         ? vec_lo_val : 16'hDEAD;

    interrupt_sequencer dut (
        .clk(clk), .reset(reset), .int_req(int_req), .stall(stall),
        .pc_in(pc_in), .flags_in(flags_in), .sp_in(sp), .mem_rdata(mem_rdata),
        .busy(busy), .flush(flush), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .sp_dec(sp_dec),
        .pc_load(pc_load), .pc_out(pc_out), .flags_clear(flags_clear)
    );

    interrupt_sequencer #(.VEC_ADDR(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .reset(reset), .int_req(int_req), .stall(stall),
        .pc_in(pc_in), .flags_in(flags_in), .sp_in(sp), .mem_rdata(w_mem_rdata),
        .busy(w_busy), .flush(w_flush), .mem_read(w_mem_read), .mem_write(w_mem_write),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .sp_dec(w_sp_dec),
        .pc_load(w_pc_load), .pc_out(w_pc_out), .flags_clear(w_flags_clear)
    );

    always #5 clk = ~clk;

    // External stack pointer follows the main instance's decrement strobe.
    always @(posedge clk) begin
        if (sp_dec) sp <= sp - 32'd1;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_sp = 32'h0000_0FFF;
    wr_t         wq[$];
    logic [31:0] pq[$];
    wr_t         ow[$];
    logic [31:0] op[$];
    int          n_spdec;
    logic [63:0] busy_v, flush_v, load_v, wread_v;
    logic [31:0] pcout_a [0:63];
    logic [31:0] maddr_a [0:63];
    logic [15:0] mwdata_a[0:63];
    logic [31:0] waddr_a [0:63];
    logic [31:0] wpc_a   [0:63];

    // Drives int_req/stall per cycle and records what the DUT presents mid-cycle.
    task automatic run(input logic [63:0] rmask, input logic [63:0] smask, input int ncyc);
        ow.delete(); op.delete();
        n_spdec = 0;
        busy_v = '0; flush_v = '0; load_v = '0; wread_v = '0;
        int_req = rmask[0];
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk);
            #1;
            int_req = rmask[cyc];
            stall   = smask[cyc];
            @(negedge clk);
            busy_v[cyc]   = busy;
            flush_v[cyc]  = flush;
            load_v[cyc]   = pc_load;
            wread_v[cyc]  = w_mem_read;
            pcout_a[cyc]  = pc_out;
            maddr_a[cyc]  = mem_addr;
            mwdata_a[cyc] = mem_wdata;
            waddr_a[cyc]  = w_mem_addr;
            wpc_a[cyc]    = w_pc_out;
            if (sp_dec) n_spdec++;
            if (mem_write && !stall) ow.push_back('{addr: mem_addr, data: mem_wdata});
            if (pc_load) op.push_back(pc_out);
        end
        int_req = 1'b0;
        stall   = 1'b0;
    endtask

    task automatic expect_push(input logic [31:0] pc, input logic [2:0] fl);
        wq.push_back('{addr: exp_sp,         data: pc[31:16]});
        wq.push_back('{addr: exp_sp - 32'd1, data: pc[15:0]});
        wq.push_back('{addr: exp_sp - 32'd2, data: {13'd0, fl}});
        exp_sp = exp_sp - 32'd3;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({busy, flush, mem_read, mem_write, sp_dec, pc_load, flags_clear} !== 7'd0) begin
            errors++; $display("FAIL reset_strobes got %b expected 0",
                {busy, flush, mem_read, mem_write, sp_dec, pc_load, flags_clear});
        end
        checks++;
        if ({mem_addr, mem_wdata, pc_out} !== 80'd0) begin
            errors++; $display("FAIL reset_buses got %h %h %h expected 0", mem_addr, mem_wdata, pc_out);
        end
        checks++;
        if ({w_busy, w_flush, w_mem_read, w_mem_write, w_sp_dec, w_pc_load, w_flags_clear,
             w_mem_addr, w_mem_wdata, w_pc_out} !== 87'd0) begin
            errors++; $display("FAIL reset_wrap_dut got %h expected 0", w_pc_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        wr_t o, e;
        pc_in = 32'h0001_2345; flags_in = 3'b101; vec_hi_val = 16'h0000; vec_lo_val = 16'h0040;
        expect_push(pc_in, flags_in);
        pq.push_back(32'h0000_0040);
        run(64'h1, 64'h0, 10);
        checks++;
        if ($countones(busy_v) != 7 || busy_v[8:1] !== 8'h7F) begin
            errors++; $display("FAIL basic_busy got %b expected 01111111", busy_v[8:1]);
        end
        checks++;
        if (flush_v[8:1] !== 8'h01) begin
            errors++; $display("FAIL basic_flush got %b expected 00000001", flush_v[8:1]);
        end
        checks++;
        if (load_v[8:1] !== 8'h40 || pcout_a[7] !== 32'h0000_0040) begin
            errors++; $display("FAIL basic_load got %b pc %h expected 01000000 pc 00000040", load_v[8:1], pcout_a[7]);
        end
        checks++;
        if (n_spdec != 3) begin
            errors++; $display("FAIL basic_spdec got %0d expected 3", n_spdec);
        end
        checks++;
        if (ow.size() != wq.size()) begin
            errors++; $display("FAIL basic_wr_count got %0d expected %0d", ow.size(), wq.size());
        end
        while (ow.size() > 0 && wq.size() > 0) begin
            o = ow.pop_front(); e = wq.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL basic_wr got %h@%h expected %h@%h", o.data, o.addr, e.data, e.addr); end
        end
        while (op.size() > 0 && pq.size() > 0) begin
            checks++;
            if (op[0] !== pq[0]) begin errors++; $display("FAIL basic_pc got %h expected %h", op[0], pq[0]); end
            void'(op.pop_front()); void'(pq.pop_front());
        end
        wq.delete(); pq.delete();
    endtask

    task automatic test_vec_wrap;
        wr_t o, e;
        pc_in = 32'h0BAD_F00D; flags_in = 3'b011; vec_hi_val = 16'h1234; vec_lo_val = 16'hABCD;
        expect_push(pc_in, flags_in);
        run(64'h1, 64'h0, 9);
        checks++;
        if (wread_v[6:5] !== 2'b11 || waddr_a[5] !== 32'hFFFF_FFFF || waddr_a[6] !== 32'd0) begin
            errors++; $display("FAIL wrap_addr got %h,%h expected ffffffff,00000000", waddr_a[5], waddr_a[6]);
        end
        checks++;
        if (wpc_a[7] !== 32'h1234_ABCD || pcout_a[7] !== 32'h1234_ABCD) begin
            errors++; $display("FAIL wrap_pc got %h/%h expected 1234abcd", wpc_a[7], pcout_a[7]);
        end
        checks++;
        if (ow.size() != wq.size()) begin
            errors++; $display("FAIL wrap_wr_count got %0d expected %0d", ow.size(), wq.size());
        end
        while (ow.size() > 0 && wq.size() > 0) begin
            o = ow.pop_front(); e = wq.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL wrap_wr got %h@%h expected %h@%h", o.data, o.addr, e.data, e.addr); end
        end
        wq.delete();
    endtask

    task automatic test_stall_push_lo;
        wr_t o, e;
        logic frozen;
        pc_in = 32'hCAFE_0001; flags_in = 3'b010; vec_hi_val = 16'h0000; vec_lo_val = 16'h0080;
        expect_push(pc_in, flags_in);
        pq.push_back(32'h0000_0080);
        run(64'h1, 64'h38, 13);
        frozen = 1'b1;
        for (int c = 3; c <= 6; c++) begin
            if (maddr_a[c] !== exp_sp + 32'd2 || mwdata_a[c] !== 16'h0001) frozen = 1'b0;
        end
        checks++;
        if (!frozen) begin
            errors++; $display("FAIL stall_frozen got %h@%h expected 0001@%h", mwdata_a[4], maddr_a[4], exp_sp + 32'd2);
        end
        checks++;
        if ($countones(busy_v) != 10 || busy_v[11:10] !== 2'b01) begin
            errors++; $display("FAIL stall_busy got %0d expected 10", $countones(busy_v));
        end
        checks++;
        if (n_spdec != 3) begin
            errors++; $display("FAIL stall_spdec got %0d expected 3", n_spdec);
        end
        checks++;
        if (load_v[10] !== 1'b1) begin
            errors++; $display("FAIL stall_load got %b expected 1", load_v[10]);
        end
        checks++;
        if (ow.size() != wq.size() || op.size() != pq.size()) begin
            errors++; $display("FAIL stall_counts got %0d/%0d expected %0d/%0d", ow.size(), op.size(), wq.size(), pq.size());
        end
        while (ow.size() > 0 && wq.size() > 0) begin
            o = ow.pop_front(); e = wq.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL stall_wr got %h@%h expected %h@%h", o.data, o.addr, e.data, e.addr); end
        end
        while (op.size() > 0 && pq.size() > 0) begin
            checks++;
            if (op[0] !== pq[0]) begin errors++; $display("FAIL stall_pc got %h expected %h", op[0], pq[0]); end
            void'(op.pop_front()); void'(pq.pop_front());
        end
        wq.delete(); pq.delete();
    endtask

    task automatic test_int_during_seq;
        wr_t o, e;
        pc_in = 32'h0000_BEEF; flags_in = 3'b111; vec_hi_val = 16'h8000; vec_lo_val = 16'h0100;
        expect_push(pc_in, flags_in);
        expect_push(pc_in, flags_in);
        pq.push_back(32'h8000_0100);
        pq.push_back(32'h8000_0100);
        run(64'hA1, 64'h60, 22);
        checks++;
        if (busy_v[10] !== 1'b0 || busy_v[11] !== 1'b1 || busy_v[9] !== 1'b1) begin
            errors++; $display("FAIL pend_gap got %b expected 101", busy_v[11:9]);
        end
        checks++;
        if ($countones(busy_v) != 16 || busy_v[22:18] !== 5'd0) begin
            errors++; $display("FAIL pend_busy got %0d expected 16", $countones(busy_v));
        end
        checks++;
        if ($countones(load_v) != 2 || load_v[9] !== 1'b1 || load_v[17] !== 1'b1) begin
            errors++; $display("FAIL pend_load got %0d expected 2", $countones(load_v));
        end
        checks++;
        if (n_spdec != 6 || $countones(flush_v) != 2) begin
            errors++; $display("FAIL pend_spdec got %0d flush %0d expected 6 flush 2", n_spdec, $countones(flush_v));
        end
        checks++;
        if (ow.size() != wq.size() || op.size() != pq.size()) begin
            errors++; $display("FAIL pend_counts got %0d/%0d expected %0d/%0d", ow.size(), op.size(), wq.size(), pq.size());
        end
        while (ow.size() > 0 && wq.size() > 0) begin
            o = ow.pop_front(); e = wq.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL pend_wr got %h@%h expected %h@%h", o.data, o.addr, e.data, e.addr); end
        end
        while (op.size() > 0 && pq.size() > 0) begin
            checks++;
            if (op[0] !== pq[0]) begin errors++; $display("FAIL pend_pc got %h expected %h", op[0], pq[0]); end
            void'(op.pop_front()); void'(pq.pop_front());
        end
        wq.delete(); pq.delete();
    endtask

    task automatic test_stall_flush_load;
        pc_in = 32'h1111_2222; flags_in = 3'b000; vec_hi_val = 16'h0000; vec_lo_val = 16'h0040;
        expect_push(pc_in, flags_in);
        run(64'h1, 64'h82, 9);
        checks++;
        if ($countones(busy_v) != 7 || busy_v[8] !== 1'b0) begin
            errors++; $display("FAIL fl_busy got %0d expected 7", $countones(busy_v));
        end
        checks++;
        if (flush_v[9:1] !== 9'h001 || load_v[9:1] !== 9'h040) begin
            errors++; $display("FAIL fl_len got flush %b load %b expected 000000001 001000000", flush_v[9:1], load_v[9:1]);
        end
        checks++;
        if (ow.size() != 3 || n_spdec != 3) begin
            errors++; $display("FAIL fl_push got %0d writes %0d dec expected 3 3", ow.size(), n_spdec);
        end
        wq.delete();
    endtask

    task automatic test_reset_mid;
        wr_t e;
        logic quiet;
        pc_in = 32'h5555_6666; flags_in = 3'b001;
        wq.push_back('{addr: exp_sp, data: 16'h5555});
        int_req = 1'b1;
        @(posedge clk); #1 int_req = 1'b0;
        @(posedge clk); #1 int_req = 1'b1;
        @(negedge clk);
        e = wq.pop_front();
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.data) begin
            errors++; $display("FAIL rmid_push_hi got %b %h@%h expected 1 %h@%h", mem_write, mem_wdata, mem_addr, e.data, e.addr);
        end
        @(posedge clk); #1 int_req = 1'b0;
        checks++;
        if (mem_write !== 1'b1 || mem_wdata !== 16'h6666) begin
            errors++; $display("FAIL rmid_push_lo got %b %h expected 1 6666", mem_write, mem_wdata);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, flush, mem_read, mem_write, sp_dec, pc_load, flags_clear, mem_addr, mem_wdata, pc_out} !== 87'd0) begin
            errors++; $display("FAIL rmid_async got busy %b wr %b addr %h pc %h expected all 0", busy, mem_write, mem_addr, pc_out);
        end
        exp_sp = exp_sp - 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy || mem_write || flush) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL rmid_replay got activity expected idle");
        end
        checks++;
        if (sp !== exp_sp) begin
            errors++; $display("FAIL rmid_sp got %h expected %h", sp, exp_sp);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_vec_wrap;
        test_stall_push_lo;
        test_int_during_seq;
        test_stall_flush_load;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Sits directly downstream of the interrupt state machine. Consumes its one-cycle interrupt pulse, flushes the pipeline front end, and pushes the return PC and the flags onto the stack. It then fetches the interrupt vector from data memory and redirects the PC. It owns the data-memory port and the stack-pointer decrement for the duration of the sequence.

## Interface
Parameters:
- `PC_WIDTH`, 32: program counter width; must equal 2×`DATA_WIDTH`.
- `DATA_WIDTH`, 16: data-memory word width.
- `ADDR_WIDTH`, 32: data-memory address width.
- `FLAG_WIDTH`, 3: flag register width (≤ `DATA_WIDTH`).
- `VEC_ADDR`, 2: word address of the vector high half; the low half is at `VEC_ADDR+1` mod 2^`ADDR_WIDTH`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `int_req`  in  1  interrupt pulse from the interrupt state machine.
- `stall`  in  1  memory/pipeline stall; freezes sequencing.
- `pc_in`  in  `PC_WIDTH`  return PC supplied by the pipeline.
- `flags_in`  in  `FLAG_WIDTH`  current flags.
- `sp_in`  in  `ADDR_WIDTH`  current stack pointer.
- `mem_rdata`  in  `DATA_WIDTH`  combinational read data, valid in the same cycle as `mem_read`.
- `busy`  out  1  sequence in progress; pipeline must not issue.
- `flush`  out  1  flush the fetch/decode stages.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `mem_addr`  out  `ADDR_WIDTH`  memory address.
- `mem_wdata`  out  `DATA_WIDTH`  memory write data.
- `sp_dec`  out  1  decrement SP by 1 at this edge.
- `pc_load`  out  1  load `pc_out` into the PC.
- `pc_out`  out  `PC_WIDTH`  vector target.
- `flags_clear`  out  1  clear the flags.

## Operation
- Moore FSM with states IDLE, FLUSH, PUSH_HI, PUSH_LO, PUSH_FL, VEC_HI, VEC_LO, LOAD. Outputs decode from registered state only, except `sp_dec`, which is qualified by `!stall`.
- **IDLE:** all outputs 0. If `int_req`=1 at an edge, or `pending`=1, then:
  - capture `pc_in` into `pc_snap` and `flags_in` into `fl_snap`;
  - clear `pending`;
  - go to FLUSH.
- **FLUSH:** `busy`=1, `flush`=1. Advances unconditionally.
- **PUSH_HI:** `mem_write`=1, `mem_addr`=`sp_in`, `mem_wdata`=`pc_snap[PC_WIDTH-1:DATA_WIDTH]`, `sp_dec`=!`stall`.
- **PUSH_LO:** same as PUSH_HI, with `mem_wdata`=`pc_snap[DATA_WIDTH-1:0]`.
- **PUSH_FL:** same as PUSH_HI, with `mem_wdata`=`fl_snap` zero-extended.
- **VEC_HI:** `mem_read`=1, `mem_addr`=`VEC_ADDR`. Captures `mem_rdata` into `vec_hi` at the advancing edge.
- **VEC_LO:** `mem_read`=1, `mem_addr`=`VEC_ADDR+1` (wraps mod 2^`ADDR_WIDTH`). Captures into `vec_lo`.
- **LOAD:** `pc_load`=1, `flags_clear`=1, `pc_out`={`vec_hi`,`vec_lo`}. Advances unconditionally to IDLE.
- **Stall:** PUSH_* and VEC_* states hold while `stall`=1, with outputs held stable; they advance on the first edge with `stall`=0. FLUSH and LOAD ignore `stall`.
- **Pending interrupt:** `int_req`=1 in any non-IDLE state sets `pending`. The pending interrupt starts a new sequence from IDLE, giving a minimum of 1 IDLE cycle between sequences. Further requests while `pending`=1 are merged.
- **Width rule:** the SP is owned externally; `mem_addr` uses `sp_in` as presented each cycle, so each push writes at the post-decrement SP of the previous push.
- `pc_out` holds its last value outside LOAD and resets to 0.

## Timing
- **Reset** (`reset`=0, asynchronous): state=IDLE; `pending`, `pc_snap`, `fl_snap`, `vec_hi`, `vec_lo`=0. Every output is 0 immediately, without waiting for a clock edge.
- **Reset mid-sequence:** abort immediately. No further writes; SP is not restored; the lost interrupt is not replayed.
- **Latency with no stall:**
  - `int_req` is sampled at edge E0.
  - FLUSH occupies cycle 1, PUSH_HI–PUSH_FL cycles 2–4, VEC_HI/VEC_LO cycles 5–6, and LOAD cycle 7.
  - IDLE returns at cycle 8.
  - `busy`=1 for exactly 7 cycles.
- **Stall cost:** each stalled cycle in a PUSH_* or VEC_* state adds exactly 1 cycle.
- **`sp_dec` count:** asserted on exactly 3 edges per sequence, regardless of stalls.

## Test plan
- **Basic sequence:**
  - Stimulus: `pc_in`=0x0001_2345, `flags_in`=3'b101, `sp_in` starting at 0x0FFF and decremented per `sp_dec`, mem[2]=0x0000, mem[3]=0x0040, pulse `int_req`.
  - Required response: writes 0x0001@0x0FFF, 0x2345@0x0FFE, 0x0005@0x0FFD; `pc_load` with `pc_out`=0x0000_0040 in cycle 7; `busy` high for 7 cycles.
- **Stall during PUSH_LO:** hold `stall`=1 for 3 cycles in PUSH_LO -> outputs frozen, exactly 3 `sp_dec` total, `busy` high for 10 cycles.
- **Interrupt during a sequence:** pulse `int_req` twice during VEC_HI -> one IDLE cycle after LOAD, then exactly one additional full sequence.
- **Reset mid-sequence:** drop `reset` during PUSH_LO (asynchronously, between edges) -> all outputs 0 within the same cycle; state IDLE; no pending replay after release.
- **Vector address wrap:** `VEC_ADDR`=2^`ADDR_WIDTH`−1 -> VEC_LO reads address 0.
- **Stall in FLUSH/LOAD:** `stall`=1 throughout FLUSH and LOAD -> both last exactly 1 cycle.
